// File: rtl/mult_stall_controller.sv
// Pipeline stall controller for a multi-cycle multiplier in EX, with load-use arbitration.
// Optional stall-cycle counter enabled by defining MULT_STALL_CNT_EN.
module mult_stall_controller #(
  parameter int MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mult__ID_EX,
  input  logic        load_use_stall,
  output logic        pc_write,
  output logic        enable__IF_ID,
  output logic        enable__ID_EX,
  output logic        flush__ID_EX,
  output logic        bubble__EX_MEM,
  output logic        mult_start,
  output logic        mult_done,
  output logic [15:0] stall_cycles
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_LOAD  = 4'(MULT_LATENCY - 2);
  localparam logic [1:0] FIRST_ST  = (MULT_LATENCY == 2) ? DONE : BUSY;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mstall;
  logic       lu_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mult__ID_EX) begin
          cnt_d   = CNT_LOAD;
          state_d = FIRST_ST;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The multiply always wins over load-use so the instruction held in ID/EX is never flushed.
  assign mstall   = (state_q == BUSY) || ((state_q == IDLE) && mult__ID_EX);
  assign lu_stall = load_use_stall && !mstall && (state_q != DONE);

  assign pc_write       = !(mstall || lu_stall);
  assign enable__IF_ID  = !(mstall || lu_stall);
  assign enable__ID_EX  = !mstall;
  assign flush__ID_EX   = lu_stall;
  assign bubble__EX_MEM = mstall;
  assign mult_start     = (state_q == IDLE) && mult__ID_EX;
  assign mult_done      = (state_q == DONE);

`ifdef MULT_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (mstall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_mult_stall_controller.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a negedge monitor pops and compares.
module tb_mult_stall_controller;

  // {pc_write, enable__IF_ID, enable__ID_EX, flush__ID_EX, bubble__EX_MEM, mult_start, mult_done}
  localparam logic [6:0] NORM   = 7'b1110000;
  localparam logic [6:0] MSTART = 7'b0000110;
  localparam logic [6:0] MBUSY  = 7'b0000100;
  localparam logic [6:0] MDONE  = 7'b1110001;
  localparam logic [6:0] LU     = 7'b0011000;

`ifdef MULT_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic [6:0]  o;
    logic [15:0] s;
    logic [6:0]  o2;
    logic [15:0] s2;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n;
  logic mult, lu, mult2, lu2, mult3;

  logic pc_w, en_ifid, en_idex, flush, bub, mstart, mdone;
  logic [15:0] sc;
  logic pc_w2, en_ifid2, en_idex2, flush2, bub2, mstart2, mdone2;
  logic [15:0] sc2;
  logic pc_w3, en_ifid3, en_idex3, flush3, bub3, mstart3, mdone3;
  logic [15:0] sc3;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  mult_stall_controller #(.MULT_LATENCY(4)) dut (
    .clk(clk), .arst_n(arst_n), .mult__ID_EX(mult), .load_use_stall(lu),
    .pc_write(pc_w), .enable__IF_ID(en_ifid), .enable__ID_EX(en_idex),
    .flush__ID_EX(flush), .bubble__EX_MEM(bub), .mult_start(mstart),
    .mult_done(mdone), .stall_cycles(sc));

  mult_stall_controller #(.MULT_LATENCY(2)) dut2 (
    .clk(clk), .arst_n(arst_n), .mult__ID_EX(mult2), .load_use_stall(lu2),
    .pc_write(pc_w2), .enable__IF_ID(en_ifid2), .enable__ID_EX(en_idex2),
    .flush__ID_EX(flush2), .bubble__EX_MEM(bub2), .mult_start(mstart2),
    .mult_done(mdone2), .stall_cycles(sc2));

  mult_stall_controller #(.MULT_LATENCY(16)) dut3 (
    .clk(clk), .arst_n(arst_n), .mult__ID_EX(mult3), .load_use_stall(1'b0),
    .pc_write(pc_w3), .enable__IF_ID(en_ifid3), .enable__ID_EX(en_idex3),
    .flush__ID_EX(flush3), .bubble__EX_MEM(bub3), .mult_start(mstart3),
    .mult_done(mdone3), .stall_cycles(sc3));

  function automatic logic [15:0] s(input int n);
    return CNT_ON ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge and queue what both DUTs must show.
  task automatic vec(input logic m, input logic l, input logic [6:0] o, input int n,
                     input logic m2, input logic [6:0] o2, input int n2);
    exp_t e;
    @(posedge clk);
    #1;
    mult = m; lu = l; mult2 = m2; lu2 = 1'b0;
    e.o = o; e.s = s(n); e.o2 = o2; e.s2 = s(n2);
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ctl_L4", {9'd0, pc_w, en_ifid, en_idex, flush, bub, mstart, mdone}, {9'd0, e.o});
      chk("cnt_L4", sc, e.s);
      chk("ctl_L2", {9'd0, pc_w2, en_ifid2, en_idex2, flush2, bub2, mstart2, mdone2}, {9'd0, e.o2});
      chk("cnt_L2", sc2, e.s2);
    end
  end

  initial begin
    arst_n = 1'b0;
    mult = 1'b0; lu = 1'b0; mult2 = 1'b0; lu2 = 1'b0; mult3 = 1'b0;
    #1;
    chk("rst_ctl", {9'd0, pc_w, en_ifid, en_idex, flush, bub, mstart, mdone}, {9'd0, NORM});
    chk("rst_cnt", sc, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // Single multiply; dropping mult__ID_EX in BUSY must not abort it.
    vec(1, 0, MSTART, 0, 0, NORM, 0);
    vec(0, 0, MBUSY,  1, 0, NORM, 0);
    vec(0, 0, MBUSY,  2, 0, NORM, 0);
    vec(0, 0, MDONE,  3, 0, NORM, 0);
    vec(0, 0, NORM,   3, 0, NORM, 0);

    // Back-to-back multiplies: starts 4 cycles apart, 6 stall cycles total.
    vec(1, 0, MSTART, 3, 0, NORM, 0);
    vec(1, 0, MBUSY,  4, 0, NORM, 0);
    vec(1, 0, MBUSY,  5, 0, NORM, 0);
    vec(1, 0, MDONE,  6, 0, NORM, 0);
    vec(1, 0, MSTART, 6, 0, NORM, 0);
    vec(0, 0, MBUSY,  7, 0, NORM, 0);
    vec(0, 0, MBUSY,  8, 0, NORM, 0);
    vec(0, 0, MDONE,  9, 0, NORM, 0);
    vec(0, 0, NORM,   9, 0, NORM, 0);

    // Plain load-use bubble.
    vec(0, 1, LU,     9, 0, NORM, 0);
    vec(0, 0, NORM,   9, 0, NORM, 0);

    // Load-use held across a multiply: no flush until after DONE.
    vec(1, 1, MSTART, 9,  0, NORM, 0);
    vec(0, 1, MBUSY,  10, 0, NORM, 0);
    vec(0, 1, MBUSY,  11, 0, NORM, 0);
    vec(0, 1, MDONE,  12, 0, NORM, 0);
    vec(0, 1, LU,     12, 0, NORM, 0);
    vec(0, 0, NORM,   12, 0, NORM, 0);

    // Asynchronous reset between edges while BUSY.
    vec(1, 0, MSTART, 12, 0, NORM, 0);
    @(posedge clk);
    #1 mult = 1'b0;
    #1 arst_n = 1'b0;
    #1;
    chk("arst_ctl", {9'd0, pc_w, en_ifid, en_idex, flush, bub, mstart, mdone}, {9'd0, NORM});
    chk("arst_cnt", sc, 16'd0);
    #1 arst_n = 1'b1;

    vec(1, 0, MSTART, 0, 0, NORM, 0);
    vec(0, 0, MBUSY,  1, 0, NORM, 0);
    vec(0, 0, MBUSY,  2, 0, NORM, 0);
    vec(0, 0, MDONE,  3, 0, NORM, 0);
    vec(0, 0, NORM,   3, 0, NORM, 0);

    // Minimum latency instance: one stall cycle, straight to DONE.
    vec(0, 0, NORM, 3, 1, MSTART, 0);
    vec(0, 0, NORM, 3, 0, MDONE,  1);
    vec(0, 0, NORM, 3, 0, NORM,   1);
    vec(0, 0, NORM, 3, 1, MSTART, 1);
    vec(0, 0, NORM, 3, 1, MDONE,  2);
    vec(0, 0, NORM, 3, 1, MSTART, 2);
    vec(0, 0, NORM, 3, 0, MDONE,  3);
    vec(0, 0, NORM, 3, 0, NORM,   3);

    begin : drain
      int budget = 20;
      while (sbq.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (sbq.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
      end
    end

    // Saturation: L=16 continuously busy stalls 15 of every 16 cycles.
    mult3 = 1'b1;
`ifdef MULT_STALL_CNT_EN
    repeat (70000) @(posedge clk);
    #1 chk("sat_hold", sc3, 16'hFFFF);
    repeat (40) @(posedge clk);
    #1 chk("sat_nowrap", sc3, 16'hFFFF);
`else
    repeat (40) @(posedge clk);
    #1 chk("cnt_off", sc3, 16'd0);
`endif
    mult3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_stall_controller.md
MULT_STALL_CONTROLLER -- requirements
Module: mult_stall_controller

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 4, total EX-stage occupancy of one multiply in cycles; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port arst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port mult__ID_EX  input  1  ID/EX register holds a valid multiply instruction.
REQ-005 SHALL have port load_use_stall  input  1  load-use hazard request from the hazard detection logic.
REQ-006 SHALL have port pc_write  output  1  PC update enable.
REQ-007 SHALL have port enable__IF_ID  output  1  IF/ID register enable.
REQ-008 SHALL have port enable__ID_EX  output  1  ID/EX register enable.
REQ-009 SHALL have port flush__ID_EX  output  1  insert bubble into ID/EX (load-use).
REQ-010 SHALL have port bubble__EX_MEM  output  1  insert bubble into EX/MEM while multiply is incomplete.
REQ-011 SHALL have port mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-012 SHALL have port mult_done  output  1  multiplier result valid; EX/MEM captures it this cycle.
REQ-013 SHALL have port stall_cycles  output  16  count of multiply stall cycles.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE plus a 4-bit down-counter cnt.
REQ-015 IDLE with mult__ID_EX=1 SHALL assert mult_start=1 and load cnt=MULT_LATENCY-2; next state DONE if MULT_LATENCY=2, else BUSY.
REQ-016 BUSY SHALL decrement cnt each cycle; next state DONE when cnt=1, else BUSY.
REQ-017 DONE SHALL assert mult_done=1, all stall outputs deasserted; next state IDLE unconditionally.
REQ-018 Multiply stall (mstall) SHALL be active in BUSY and in IDLE with mult__ID_EX=1; DONE is not stalled.
REQ-019 During mstall: pc_write=0, enable__IF_ID=0, enable__ID_EX=0, bubble__EX_MEM=1, flush__ID_EX=0.
REQ-020 Latency: multiply occupies EX exactly MULT_LATENCY cycles, of which MULT_LATENCY-1 are stall cycles.
REQ-021 Back-to-back multiplies: a new multiply arriving in ID/EX in the cycle after DONE SHALL be started from IDLE with no extra gap.
REQ-022 load_use_stall with no mstall SHALL give pc_write=0, enable__IF_ID=0, enable__ID_EX=1, flush__ID_EX=1, bubble__EX_MEM=0.
REQ-023 Simultaneous load_use_stall and mstall: mstall wins; flush__ID_EX SHALL stay 0 so the multiply is never destroyed; load_use_stall re-evaluated after DONE.
REQ-024 No stall and no multiply: pc_write=1, enable__IF_ID=1, enable__ID_EX=1, flush__ID_EX=0, bubble__EX_MEM=0, mult_start=0, mult_done=0.
REQ-025 All outputs except stall_cycles SHALL be combinational from state, cnt and inputs; mult__ID_EX deasserting in BUSY SHALL NOT abort the sequence.

Reset
REQ-026 arst_n=0 SHALL immediately force state=IDLE, cnt=0, stall_cycles=0, independent of clk.
REQ-027 Reset mid-multiply SHALL abandon it; after release, an asserted mult__ID_EX starts a fresh full sequence.

Configuration
REQ-028 Macro MULT_STALL_CNT_EN defined: stall_cycles increments by 1 each cycle mstall=1, saturating at 0xFFFF.
REQ-029 Macro MULT_STALL_CNT_EN undefined: no counter register; stall_cycles SHALL be constant 0.

Verification
REQ-030 MULT_LATENCY=4, mult__ID_EX=1 one instruction -> mult_start in cycle 0, stall cycles 0-2, mult_done cycle 3, pc_write=1 cycle 3.
REQ-031 MULT_LATENCY=2 -> stall in cycle 0 only, mult_done cycle 1, no BUSY visited.
REQ-032 Two consecutive multiplies, L=4 -> mult_done at cycles 3 and 7, mult_start at 0 and 4; stall_cycles=6 with macro, 0 without.
REQ-033 load_use_stall=1 asserted during BUSY -> flush__ID_EX=0 throughout; load-use bubble only after DONE if still requested.
REQ-034 arst_n pulsed low in BUSY between clock edges -> outputs immediately at IDLE values; next multiply takes full 4 cycles.
REQ-035 stall_cycles preloaded near 0xFFFF by long run with macro -> holds 0xFFFF, no wrap.
